// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
// Builds the matcher next-state table and pattern border length.
package seq_det_pkg;

  localparam int MAX_W  = 16;
  localparam int TBL_SW = 4;
  localparam int IDX_W  = 5;

  typedef logic [2*MAX_W-1:0][TBL_SW-1:0] ns_tbl_t;

  function automatic int st_width(input int w);
    return $clog2(w);
  endfunction

  // Longest proper prefix of pat that is also a suffix.
  function automatic int border_len(
    input logic [MAX_W-1:0] pat,
    input int w
  );
    int best;
    logic ok;
    best = 0;
    for (int k = 1; k < w; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++)
        if (pat[w-1-i] != pat[k-1-i]) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction

  function automatic ns_tbl_t next_tbl(
    input logic [MAX_W-1:0] pat,
    input int w
  );
    ns_tbl_t t;
    logic [MAX_W-1:0] c;
    logic ok;
    int best;
    t = '0;
    for (int s = 0; s < w; s++) begin
      for (int b = 0; b < 2; b++) begin
        c = '0;
        for (int j = 0; j < s; j++) c[j] = pat[w-1-j];
        c[s] = (b == 1);
        if (s == w-1 && c[s] == pat[0]) begin
          t[2*s+b] = TBL_SW'(border_len(pat, w));
        end else begin
          best = 0;
          for (int k = 1; k <= s+1; k++) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++)
              if (pat[w-1-i] != c[s+1-k+i]) ok = 1'b0;
            if (ok) best = k;
          end
          t[2*s+b] = TBL_SW'(best);
        end
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter with synchronous clear and sticky
// saturation flag.
module seq_match_counter #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [COUNT_W-1:0] count,
  output logic               sat
);

  localparam logic [COUNT_W-1:0] MAXV = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc && count != MAXV) begin
      count <= count + 1'b1;
      if (count == MAXV - 1'b1) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with Mealy and registered
// match outputs and runtime overlap selection.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int              PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter int              COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               in_valid,
  input  logic               overlap,
  input  logic               clr,
  output logic               out,
  output logic               out_q,
  output logic [COUNT_W-1:0] match_count,
  output logic               count_sat
);

  localparam int SW = st_width(PAT_W);
  localparam logic [MAX_W-1:0] PAT16 = MAX_W'(PATTERN);
  localparam ns_tbl_t TBL = next_tbl(PAT16, PAT_W);
  localparam logic [SW-1:0] BRD = SW'(border_len(PAT16, PAT_W));
  localparam logic [SW-1:0] LAST = SW'(PAT_W - 1);

  logic [SW-1:0]    s;
  logic [SW-1:0]    nxt;
  logic [IDX_W-1:0] idx;

  assign idx = IDX_W'({s, in});
  assign nxt = SW'(TBL[idx]);
  assign out = in_valid & (s == LAST) & (in == PATTERN[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s     <= '0;
      out_q <= 1'b0;
    end else if (clr) begin
      s     <= '0;
      out_q <= 1'b0;
    end else begin
      out_q <= out;
      if (in_valid) begin
        if (out) s <= overlap ? BRD : '0;
        else     s <= nxt;
      end
    end
  end

  seq_match_counter #(
    .COUNT_W(COUNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out),
    .clr  (clr),
    .count(match_count),
    .sat  (count_sat)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: directed streams with
// hand-written expected match pulses.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in = 1'b0;
  logic in_valid = 1'b0;
  logic overlap = 1'b0;
  logic clr = 1'b0;

  logic       o0, q0, s0;
  logic [7:0] c0;
  logic       o1, q1, s1;
  logic [1:0] c1;

  seq_detector_param #(
    .PAT_W(4), .PATTERN(4'b1010), .COUNT_W(8)
  ) dut0 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
    .overlap(overlap), .clr(clr), .out(o0), .out_q(q0),
    .match_count(c0), .count_sat(s0)
  );

  seq_detector_param #(
    .PAT_W(4), .PATTERN(4'b1101), .COUNT_W(2)
  ) dut1 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
    .overlap(overlap), .clr(clr), .out(o1), .out_q(q1),
    .match_count(c1), .count_sat(s1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         dut;
    logic       o;
    logic       oq;
    logic [7:0] cnt;
    logic       sat;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  int   cur = 0;
  int   m_max = 255;
  int   m_cnt = 0;
  logic m_oq = 1'b0;
  logic m_sat = 1'b0;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.dut == 0) begin
        chk("d0.out", {7'd0, o0}, {7'd0, e.o});
        chk("d0.out_q", {7'd0, q0}, {7'd0, e.oq});
        chk("d0.count", c0, e.cnt);
        chk("d0.sat", {7'd0, s0}, {7'd0, e.sat});
      end else begin
        chk("d1.out", {7'd0, o1}, {7'd0, e.o});
        chk("d1.out_q", {7'd0, q1}, {7'd0, e.oq});
        chk("d1.count", {6'd0, c1}, e.cnt);
        chk("d1.sat", {7'd0, s1}, {7'd0, e.sat});
      end
    end
  end

  task automatic model_clear();
    m_oq  = 1'b0;
    m_cnt = 0;
    m_sat = 1'b0;
  endtask

  task automatic drive(input logic v, input logic b,
                       input logic c, input logic eo);
    exp_t e;
    in_valid = v;
    in       = b;
    clr      = c;
    e.dut = cur;
    e.o   = eo;
    e.oq  = m_oq;
    e.cnt = m_cnt[7:0];
    e.sat = m_sat;
    sbq.push_back(e);
    if (c) begin
      model_clear();
    end else begin
      m_oq = eo;
      if (eo && m_cnt < m_max) begin
        m_cnt++;
        if (m_cnt == m_max) m_sat = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic stream(input string bits, input string eo);
    for (int i = 0; i < bits.len(); i++)
      drive(1'b1, bits.getc(i) == "1", 1'b0, eo.getc(i) == "1");
  endtask

  task automatic do_reset(input int d, input int mx);
    in_valid = 1'b0;
    in       = 1'b0;
    clr      = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    cur   = d;
    m_max = mx;
    model_clear();
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("rst.d0.out", {7'd0, o0}, 8'd0);
    chk("rst.d0.out_q", {7'd0, q0}, 8'd0);
    chk("rst.d0.count", c0, 8'd0);
    chk("rst.d0.sat", {7'd0, s0}, 8'd0);
    chk("rst.d1.out", {7'd0, o1}, 8'd0);
    chk("rst.d1.count", {6'd0, c1}, 8'd0);

    do_reset(0, 255);
    overlap = 1'b0;
    stream("1010101010", "0001000100");

    do_reset(0, 255);
    overlap = 1'b1;
    stream("1010101010", "0001010101");

    do_reset(0, 255);
    overlap = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);

    // partial match 101, then asynchronous reset between edges
    stream("101", "000");
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst.out", {7'd0, o0}, 8'd0);
    chk("arst.out_q", {7'd0, q0}, 8'd0);
    chk("arst.count", c0, 8'd0);
    #1;
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    stream("0", "0");
    stream("1010", "0001");

    // clr on a match cycle in overlap mode
    overlap = 1'b1;
    stream("101", "000");
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    stream("1010", "0001");

    do_reset(1, 3);
    overlap = 1'b1;
    stream("1101101101101101", "0001001001001001");

    @(negedge clk);
    #1;
    chk("sb.drain", 8'(sbq.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector: the next generation of the fixed 4-bit, non-overlapping 1010 Mealy detector. It matches an arbitrary PAT_W-bit pattern on a 1-bit stream qualified by a valid strobe, with runtime overlap/non-overlap selection. It provides both a Mealy (same-cycle) and a registered Moore-style match output, plus a saturating match counter. It sits on serial-input paths as a frame/sync-word spotter.

## Interface
- PAT_W, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1010, pattern value. PATTERN[PAT_W-1] is the first bit received, PATTERN[0] the last.
- COUNT_W, 8, width of the match counter.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  1  serial data bit.
- in_valid  input  1  qualifies `in`. When low, the bit is ignored and all state holds.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping. Sampled only on a match cycle.
- clr  input  1  synchronous clear of matcher state, out_q, match_count and count_sat.
- out  output  1  Mealy match pulse, combinational.
- out_q  output  1  `out` registered one cycle later.
- match_count  output  COUNT_W  number of matches since reset or clr, saturating.
- count_sat  output  1  sticky flag, high once match_count has reached all-ones.

## Operation
- **Matcher state** `s` in 0..PAT_W-1 is the length of the longest pattern prefix that is a suffix of the valid bits received so far.
- **Candidate:** on a cycle with in_valid=1 and bit b, form the candidate of length s+1, consisting of the s matched prefix bits followed by b.
- **Match:** occurs when s==PAT_W-1 and b==PATTERN[0].
- **Next state on match:**
  - overlap=1: s goes to B, where B is the length of the longest proper border of PATTERN (prefix equal to suffix). B is computed at elaboration.
  - overlap=0: s goes to 0.
- **Next state on no match:** s goes to the largest k ≤ s+1 such that the first k pattern bits equal the last k candidate bits.
- **Next-state table:** PAT_W × 2 entries, fully elaboration-time. There is no runtime pattern compare beyond the table lookup.
- **out** = in_valid & (s==PAT_W-1) & (in==PATTERN[0]).
- **out_q:** registered copy of `out`.
- **match_count:** increments by 1 on each cycle where out=1. It holds at 2^COUNT_W-1, and count_sat sets on the cycle the counter reaches that value.
- **clr:** has priority over a same-cycle match. s, out_q, match_count and count_sat all go to 0. `out` may still be high combinationally on that cycle, but the match is not counted.
- **Mode change:** a change of `overlap` mid-stream is legal and affects only the next match transition.

## Timing
- **Reset values:** s=0, out_q=0, match_count=0, count_sat=0. `out`=0 while rst is high, since s=0 and PAT_W≥2.
- **Reset mid-pattern:** a partial match is discarded. The first post-reset bit is evaluated from s=0.
- **Latency:**
  - `out` rises in the same cycle as the final pattern bit.
  - out_q and match_count update at the following rising edge.
- **in_valid gaps:** gaps of any length hold all state. The pattern may span gaps.
- **Back-to-back matches:** in overlap mode, matches may occur every PAT_W-B valid bits. `out` then pulses on each of those cycles, and the counter increments on each one.

## Structure
- **Package seq_det_pkg:**
  - a constant function computing the border length B of a pattern;
  - a constant function computing the next-state table from (PAT_W, PATTERN);
  - the state-width constant $clog2(PAT_W).
- **Sub-module seq_match_counter:** COUNT_W saturating counter with inc, clr and sat outputs. The top module contains only the state register, the table lookup and the out/out_q logic.

## Test plan
- **Non-overlap, defaults:** overlap=0, stream 1010101010 with in_valid=1 throughout → out high on bits 4 and 8 only; match_count=2.
- **Overlap, defaults:** overlap=1, same stream → out high on bits 4, 6, 8 and 10; match_count=4; out_q trails each pulse by one cycle.
- **Valid gaps:** defaults, stream 1,0,(in_valid=0 for 3 cycles with in=1),1,0 → single match on the final bit; state unaffected by the invalid cycles.
- **Reset mid-pattern:** after 1,0,1, pulse rst asynchronously between edges, then send 0 → no match, all outputs 0. Then 1010 → match, count=1.
- **Other pattern and saturation:** PATTERN=4'b1101, COUNT_W=2, overlap=1, stream 1101101101101101 → matches on bits 4, 7, 10, 13 and 16 (B=1); match_count stays at 3; count_sat=1 from the third match onward.
- **clr collision:** clr asserted on a match cycle → match_count=0 and out_q=0 next cycle; state restarts at 0.
